// File: rtl/rgb_fade_pwm.sv
// rgb_fade_pwm: cross-fading PWM driver for active-low RGB LED pins (clk, rst_n async low; red/green/blue targets in; RGB_R/G/B pins and fade_busy out)
module rgb_fade_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 7812
) (
  input  logic clk,
  input  logic rst_n,
  input  logic red,
  input  logic green,
  input  logic blue,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B,
  output logic fade_busy
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SW-1:0] step_cnt;
  logic step_tick;
  logic frame_end;
  logic [2:0] lvl;
  logic [2:0] on;
  logic [2:0] busy_nxt;
  logic [PWM_BITS-1:0] tgt [3];
  logic [PWM_BITS-1:0] duty [3];
  logic [PWM_BITS-1:0] duty_nxt [3];
  logic [PWM_BITS-1:0] duty_act [3];
  assign lvl = {blue, green, red};
  assign step_tick = step_cnt == STEP_LAST;
  assign frame_end = pwm_cnt == MAX;
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      tgt[i] = lvl[i] ? MAX : '0;
      duty_nxt[i] = !step_tick ? duty[i] :
                    duty[i] < tgt[i] ? duty[i] + PWM_BITS'(1) :
                    duty[i] > tgt[i] ? duty[i] - PWM_BITS'(1) : duty[i];
      busy_nxt[i] = duty_nxt[i] != tgt[i];
      on[i] = pwm_cnt < duty_act[i] || duty_act[i] == MAX;
    end
  end
  // The shadow samples the pre-step duty, so a coincident step lands one period later.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pwm_cnt <= '0;
      step_cnt <= '0;
      fade_busy <= 1'b0;
      {RGB_B, RGB_G, RGB_R} <= '1;
      for (int i = 0; i < 3; i++) begin
        duty[i] <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      step_cnt <= step_tick ? '0 : step_cnt + SW'(1);
      fade_busy <= |busy_nxt;
      {RGB_B, RGB_G, RGB_R} <= ~on;
      for (int i = 0; i < 3; i++) begin
        duty[i] <= duty_nxt[i];
        if (frame_end) duty_act[i] <= duty[i];
      end
    end
endmodule

// File: tb/tb_rgb_fade_pwm.sv
// tb_rgb_fade_pwm: directed checks of fade timing, shadow loading, pulse widths and reset for rgb_fade_pwm
module tb_rgb_fade_pwm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic red = 1'b0;
  logic green = 1'b0;
  logic blue = 1'b0;
  logic RGB_R, RGB_G, RGB_B, fade_busy;
  logic [2:0] pins;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int red_off_at = -1;
  int g_lit_from = 0;
  bit toggle = 1'b0;
  rgb_fade_pwm #(.PWM_BITS(4), .STEP_DIV(4)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .red(red),
    .green(green),
    .blue(blue),
    .RGB_R(RGB_R),
    .RGB_G(RGB_G),
    .RGB_B(RGB_B),
    .fade_busy(fade_busy)
  );
  assign pins = {RGB_B, RGB_G, RGB_R};
  always #5 clk = ~clk;
  task automatic chkv(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == red_off_at) red = 1'b0;
    if (toggle && cyc >= 21 && (cyc - 21) % 4 == 0) red = (((cyc - 21) / 4) % 2) == 1;
    if (g_lit_from > 0 && cyc >= g_lit_from) chkv("green_hold", 8'(RGB_G), 8'd0);
  endtask
  task automatic do_reset(input logic r, input logic g, input logic b);
    rst_n = 1'b0;
    red = r;
    green = g;
    blue = b;
    red_off_at = -1;
    g_lit_from = 0;
    toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkv("reset_state", 8'({RGB_R, RGB_G, RGB_B, fade_busy}), 8'hE);
    rst_n = 1'b1;
    cyc = 0;
  endtask
  task automatic chk_period(input int ch, input int da, input int b_lo, input int b_hi);
    int lows = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chkv($sformatf("pin%0d_duty%0d_i%0d", ch, da, i), 8'(pins[ch]), (i < da || da == 15) ? 8'd0 : 8'd1);
      chkv("busy", 8'(fade_busy), 8'(cyc >= b_lo && cyc < b_hi));
      lows += pins[ch] ? 0 : 1;
    end
    chkv($sformatf("lows%0d_duty%0d", ch, da), 8'(lows), 8'(da == 15 ? 16 : da));
  endtask
  initial begin
    // idle after reset
    do_reset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      step();
      chkv("idle", 8'({RGB_R, RGB_G, RGB_B, fade_busy}), 8'hE);
    end
    // fade up: duty 15 at clock 60, shadow loads 0,3,7,11 then 15 at clock 64
    do_reset(1'b1, 1'b0, 1'b0);
    chk_period(0, 0, 1, 60);
    chk_period(0, 3, 1, 60);
    chk_period(0, 7, 1, 60);
    chk_period(0, 11, 1, 60);
    chk_period(0, 15, 1, 60);
    chk_period(0, 15, 1, 60);
    // duty held near 5 by toggling red each tick; every boundary loads 5
    do_reset(1'b1, 1'b0, 1'b0);
    toggle = 1'b1;
    chk_period(0, 0, 1, 100000);
    chk_period(0, 3, 1, 100000);
    chk_period(0, 5, 1, 100000);
    chk_period(0, 5, 1, 100000);
    chk_period(0, 5, 1, 100000);
    // reversal: peak 5 at clock 20, back to 0 at clock 40, no wrap afterwards
    do_reset(1'b1, 1'b0, 1'b0);
    red_off_at = 22;
    chk_period(0, 0, 1, 40);
    chk_period(0, 3, 1, 40);
    chk_period(0, 3, 1, 40);
    chk_period(0, 0, 1, 40);
    chk_period(0, 0, 1, 40);
    chk_period(0, 0, 1, 40);
    // async reset with green mid-fade, then restart from 0
    do_reset(1'b0, 1'b1, 1'b0);
    chk_period(1, 0, 1, 100000);
    chk_period(1, 3, 1, 100000);
    for (int i = 0; i < 6; i++) begin
      step();
      chkv("green_pre_rst", 8'({RGB_G, fade_busy}), 8'h1);
    end
    #3 rst_n = 1'b0;
    #1 chkv("async_rst", 8'({RGB_R, RGB_G, RGB_B, fade_busy}), 8'hE);
    do_reset(1'b0, 1'b1, 1'b0);
    chk_period(1, 0, 1, 100000);
    chk_period(1, 3, 1, 100000);
    // cross-fade yellow to green: red falls 15 to 0 over clocks 64..124
    do_reset(1'b1, 1'b1, 1'b0);
    red_off_at = 64;
    g_lit_from = 65;
    chk_period(0, 0, 1, 60);
    chk_period(0, 3, 1, 60);
    chk_period(0, 7, 1, 60);
    chk_period(0, 11, 1, 60);
    chk_period(0, 15, 65, 124);
    chk_period(0, 12, 65, 124);
    chk_period(0, 8, 65, 124);
    chk_period(0, 4, 65, 124);
    chk_period(0, 0, 65, 124);
    chk_period(0, 0, 65, 124);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
